// File: rtl/reg_map_wr_arbiter.sv
// reg_map_wr_arbiter
//   Shares the single register-map write port between NUM_REQ requesters.
//   Each requester owns a one-deep slot (addr/data/keep). A round-robin FSM
//   issues one register-map write at a time, waits for completion or timeout,
//   then pulses req_done for the granted requester and reports req_err.
//
// Ports
//   aclk, aresetn           clock, synchronous active-low reset
//   req_cmd[i]              single-cycle write strobe from requester i
//   req_addr/data/keep      packed per-requester write payload
//   req_ready[i]            slot i is free (inverse of pending)
//   req_done[i]             one-cycle completion pulse to requester i
//   req_err                 error status of the most recent completion
//   reg_map_wr_cmd/addr/data/keep   registered write command to register map
//   reg_map_wr_valid/err    write completion and its error code
//   reg_map_wr_ready        register map can accept a command
module reg_map_wr_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter logic [15:0] TIMEOUT = 16'd1023
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NUM_REQ-1:0]      req_cmd,
    input  logic [8*NUM_REQ-1:0]    req_addr,
    input  logic [32*NUM_REQ-1:0]   req_data,
    input  logic [32*NUM_REQ-1:0]   req_keep,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      req_done,
    output logic [1:0]              req_err,
    output logic                    reg_map_wr_cmd,
    output logic [7:0]              reg_map_wr_addr,
    output logic [31:0]             reg_map_wr_data,
    output logic [31:0]             reg_map_wr_keep,
    input  logic                    reg_map_wr_valid,
    input  logic                    reg_map_wr_ready,
    input  logic [1:0]              reg_map_wr_err
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [7:0]         slot_addr_q [NUM_REQ];
    logic [7:0]         slot_addr_d [NUM_REQ];
    logic [31:0]        slot_data_q [NUM_REQ];
    logic [31:0]        slot_data_d [NUM_REQ];
    logic [31:0]        slot_keep_q [NUM_REQ];
    logic [31:0]        slot_keep_d [NUM_REQ];
    logic [GW-1:0]      grant_q, grant_d;
    logic [GW-1:0]      last_q, last_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               wr_cmd_q, wr_cmd_d;
    logic [7:0]         wr_addr_q, wr_addr_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic [31:0]        wr_keep_q, wr_keep_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [1:0]         err_q, err_d;

    logic               found;
    logic [GW-1:0]      pick;

    // Round-robin search: first pending slot starting just after the last grant.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && pending_q[(int'(last_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick  = GW'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        // A strobe on an occupied slot is dropped, so capture only into free slots.
        pending_d   = pending_q | (req_cmd & ~pending_q);
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        slot_keep_d = slot_keep_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_cmd[i] && !pending_q[i]) begin
                slot_addr_d[i] = req_addr[8*i +: 8];
                slot_data_d[i] = req_data[32*i +: 32];
                slot_keep_d[i] = req_keep[32*i +: 32];
            end
        end
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        wr_cmd_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_keep_d = wr_keep_q;
        done_d    = '0;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (found && reg_map_wr_ready) begin
                    grant_d   = pick;
                    wr_cmd_d  = 1'b1;
                    wr_addr_d = slot_addr_q[pick];
                    wr_data_d = slot_data_q[pick];
                    wr_keep_d = slot_keep_q[pick];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion takes precedence over a coincident timeout.
                if (reg_map_wr_valid) begin
                    err_d           = reg_map_wr_err;
                    done_d[grant_q] = 1'b1;
                    state_d         = DONE;
                end else if (cnt_q == TIMEOUT) begin
                    err_d           = 2'b11;
                    done_d[grant_q] = 1'b1;
                    state_d         = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                pending_d[grant_q] = 1'b0;
                last_d             = grant_q;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            pending_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_addr_q[i] <= '0;
                slot_data_q[i] <= '0;
                slot_keep_q[i] <= '0;
            end
            grant_q   <= '0;
            last_q    <= GW'(NUM_REQ - 1);
            cnt_q     <= '0;
            wr_cmd_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_keep_q <= '0;
            done_q    <= '0;
            err_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            slot_addr_q <= slot_addr_d;
            slot_data_q <= slot_data_d;
            slot_keep_q <= slot_keep_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            wr_cmd_q    <= wr_cmd_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_keep_q   <= wr_keep_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_ready       = ~pending_q;
    assign req_done        = done_q;
    assign req_err         = err_q;
    assign reg_map_wr_cmd  = wr_cmd_q;
    assign reg_map_wr_addr = wr_addr_q;
    assign reg_map_wr_data = wr_data_q;
    assign reg_map_wr_keep = wr_keep_q;

endmodule

// File: tb/tb_reg_map_wr_arbiter.sv
// tb_reg_map_wr_arbiter
//   Directed scenarios for reg_map_wr_arbiter followed by a randomized run
//   compared every cycle against a transaction-level reference model.
module tb_reg_map_wr_arbiter;

    localparam int TO = 16;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [3:0]   req_cmd = '0;
    logic [31:0]  req_addr = '0;
    logic [127:0] req_data = '0;
    logic [127:0] req_keep = '0;
    logic [3:0]   req_ready;
    logic [3:0]   req_done;
    logic [1:0]   req_err;
    logic         reg_map_wr_cmd;
    logic [7:0]   reg_map_wr_addr;
    logic [31:0]  reg_map_wr_data;
    logic [31:0]  reg_map_wr_keep;
    logic         reg_map_wr_valid = 1'b0;
    logic         reg_map_wr_ready = 1'b1;
    logic [1:0]   reg_map_wr_err = 2'b00;

    int checks = 0;
    int failures = 0;

    reg_map_wr_arbiter #(.NUM_REQ(4), .TIMEOUT(16'd16)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .req_cmd          (req_cmd),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_keep         (req_keep),
        .req_ready        (req_ready),
        .req_done         (req_done),
        .req_err          (req_err),
        .reg_map_wr_cmd   (reg_map_wr_cmd),
        .reg_map_wr_addr  (reg_map_wr_addr),
        .reg_map_wr_data  (reg_map_wr_data),
        .reg_map_wr_keep  (reg_map_wr_keep),
        .reg_map_wr_valid (reg_map_wr_valid),
        .reg_map_wr_ready (reg_map_wr_ready),
        .reg_map_wr_err   (reg_map_wr_err)
    );

    always #5 aclk = ~aclk;

    // Reference model: tracks which requesters hold an unserved write and the
    // life of the single in-flight transaction (0 none, 1 command on the bus,
    // 2 awaiting completion, 3 completion reported to the requester).
    logic [3:0]  m_pend;
    logic [7:0]  m_sa [4];
    logic [31:0] m_sd [4];
    logic [31:0] m_sk [4];
    int          m_stage, m_grant, m_last, m_wait;
    logic        m_cmd;
    logic [7:0]  m_oa;
    logic [31:0] m_od, m_ok;
    logic [3:0]  m_done;
    logic [1:0]  m_err;

    function automatic int rr_pick(logic [3:0] p, int last);
        for (int k = 1; k <= 4; k++)
            if (p[(last + k) % 4]) return (last + k) % 4;
        return 0;
    endfunction

    always @(posedge aclk) begin
        if (!aresetn) begin
            m_pend <= '0; m_stage <= 0; m_grant <= 0; m_last <= 3; m_wait <= 0;
            m_cmd <= 1'b0; m_oa <= '0; m_od <= '0; m_ok <= '0; m_done <= '0; m_err <= '0;
            for (int i = 0; i < 4; i++) begin
                m_sa[i] <= '0; m_sd[i] <= '0; m_sk[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req_cmd[i] && !m_pend[i]) begin
                    m_sa[i] <= req_addr[8*i +: 8];
                    m_sd[i] <= req_data[32*i +: 32];
                    m_sk[i] <= req_keep[32*i +: 32];
                end
            end
            m_pend <= (m_pend | (req_cmd & ~m_pend)) &
                      ~((m_stage == 3) ? (4'b0001 << m_grant) : 4'b0000);
            m_cmd  <= 1'b0;
            m_done <= '0;
            case (m_stage)
                0: if (m_pend != 0 && reg_map_wr_ready) begin
                    m_grant <= rr_pick(m_pend, m_last);
                    m_oa    <= m_sa[rr_pick(m_pend, m_last)];
                    m_od    <= m_sd[rr_pick(m_pend, m_last)];
                    m_ok    <= m_sk[rr_pick(m_pend, m_last)];
                    m_cmd   <= 1'b1;
                    m_stage <= 1;
                end
                1: begin m_stage <= 2; m_wait <= 0; end
                2: if (reg_map_wr_valid) begin
                    m_err <= reg_map_wr_err; m_done <= 4'b0001 << m_grant; m_stage <= 3;
                end else if (m_wait == TO) begin
                    m_err <= 2'b11; m_done <= 4'b0001 << m_grant; m_stage <= 3;
                end else begin
                    m_wait <= m_wait + 1;
                end
                default: begin m_last <= m_grant; m_stage <= 0; end
            endcase
        end
    end

    task automatic cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [7:0] a, input logic [31:0] d, input logic [31:0] k);
        req_addr[8*i +: 8]   = a;
        req_data[32*i +: 32] = d;
        req_keep[32*i +: 32] = k;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        req_cmd = 4'hF;
        reg_map_wr_valid = 1'b1;
        cycle(); cycle();
        req_cmd = '0;
        reg_map_wr_valid = 1'b0;
        checks++; if (reg_map_wr_cmd !== 1'b0) begin failures++; $display("[TB] FAIL reset_cmd got=%0b exp=0", reg_map_wr_cmd); end
        checks++; if (reg_map_wr_addr !== 8'h00) begin failures++; $display("[TB] FAIL reset_addr got=%0h exp=0", reg_map_wr_addr); end
        checks++; if (reg_map_wr_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_data got=%0h exp=0", reg_map_wr_data); end
        checks++; if (reg_map_wr_keep !== 32'h0) begin failures++; $display("[TB] FAIL reset_keep got=%0h exp=0", reg_map_wr_keep); end
        checks++; if (req_done !== 4'h0) begin failures++; $display("[TB] FAIL reset_done got=%0h exp=0", req_done); end
        checks++; if (req_err !== 2'b00) begin failures++; $display("[TB] FAIL reset_err got=%0b exp=00", req_err); end
        checks++; if (req_ready !== 4'hF) begin failures++; $display("[TB] FAIL reset_ready got=%0h exp=f", req_ready); end
        aresetn = 1'b1;
        cycle();
    endtask

    task automatic test_single_write();
        set_slot(1, 8'h23, 32'h2, 32'h3);
        req_cmd = 4'b0010;
        cycle();
        req_cmd = '0;
        checks++; if (req_ready !== 4'b1101) begin failures++; $display("[TB] FAIL single_ready_busy got=%0h exp=d", req_ready); end
        cycle();
        checks++; if (reg_map_wr_cmd !== 1'b1) begin failures++; $display("[TB] FAIL single_cmd got=%0b exp=1", reg_map_wr_cmd); end
        checks++; if (reg_map_wr_addr !== 8'h23) begin failures++; $display("[TB] FAIL single_addr got=%0h exp=23", reg_map_wr_addr); end
        checks++; if (reg_map_wr_data !== 32'h2) begin failures++; $display("[TB] FAIL single_data got=%0h exp=2", reg_map_wr_data); end
        checks++; if (reg_map_wr_keep !== 32'h3) begin failures++; $display("[TB] FAIL single_keep got=%0h exp=3", reg_map_wr_keep); end
        cycle();
        checks++; if (reg_map_wr_cmd !== 1'b0) begin failures++; $display("[TB] FAIL single_cmd_fall got=%0b exp=0", reg_map_wr_cmd); end
        checks++; if (reg_map_wr_addr !== 8'h23) begin failures++; $display("[TB] FAIL single_addr_hold got=%0h exp=23", reg_map_wr_addr); end
        reg_map_wr_valid = 1'b1;
        reg_map_wr_err   = 2'b00;
        cycle();
        reg_map_wr_valid = 1'b0;
        checks++; if (req_done !== 4'b0010) begin failures++; $display("[TB] FAIL single_done got=%0h exp=2", req_done); end
        checks++; if (req_err !== 2'b00) begin failures++; $display("[TB] FAIL single_err got=%0b exp=00", req_err); end
        checks++; if (req_ready !== 4'b1101) begin failures++; $display("[TB] FAIL single_ready_done got=%0h exp=d", req_ready); end
        cycle();
        checks++; if (req_done !== 4'h0) begin failures++; $display("[TB] FAIL single_done_pulse got=%0h exp=0", req_done); end
        checks++; if (req_ready !== 4'hF) begin failures++; $display("[TB] FAIL single_ready_free got=%0h exp=f", req_ready); end
    endtask

    task automatic test_round_robin();
        logic [7:0] q_addr[$];
        logic [3:0] q_done[$];
        aresetn = 1'b0; cycle(); aresetn = 1'b1;
        for (int i = 0; i < 4; i++) set_slot(i, 8'(8'h40 + i), 32'hA000_0000 + i, 32'hFFFF_FFFF);
        reg_map_wr_valid = 1'b1;
        reg_map_wr_err   = 2'b00;
        req_cmd = 4'hF;
        for (int c = 0; c < 60 && q_done.size() < 4; c++) begin
            cycle();
            req_cmd = '0;
            if (reg_map_wr_cmd === 1'b1) q_addr.push_back(reg_map_wr_addr);
            if (req_done !== 4'h0) q_done.push_back(req_done);
        end
        checks++; if (q_done.size() != 4 || q_addr.size() != 4) begin failures++; $display("[TB] FAIL rr_count got=%0d/%0d exp=4/4", q_addr.size(), q_done.size()); end
        for (int i = 0; i < q_done.size() && i < q_addr.size(); i++) begin
            checks++; if (q_done[i] !== 4'(4'b0001 << i)) begin failures++; $display("[TB] FAIL rr_done[%0d] got=%0h exp=%0h", i, q_done[i], 4'(4'b0001 << i)); end
            checks++; if (q_addr[i] !== 8'(8'h40 + i)) begin failures++; $display("[TB] FAIL rr_addr[%0d] got=%0h exp=%0h", i, q_addr[i], 8'(8'h40 + i)); end
        end
        cycle();
        q_addr.delete();
        q_done.delete();
        set_slot(0, 8'h50, 32'h5, 32'h1);
        set_slot(2, 8'h52, 32'h6, 32'h1);
        req_cmd = 4'b0101;
        for (int c = 0; c < 40 && q_done.size() < 2; c++) begin
            cycle();
            req_cmd = '0;
            if (reg_map_wr_cmd === 1'b1) q_addr.push_back(reg_map_wr_addr);
            if (req_done !== 4'h0) q_done.push_back(req_done);
        end
        checks++; if (q_done.size() != 2 || q_addr.size() != 2) begin failures++; $display("[TB] FAIL rr2_count got=%0d/%0d exp=2/2", q_addr.size(), q_done.size()); end
        else begin
            checks++; if (q_done[0] !== 4'b0001 || q_done[1] !== 4'b0100) begin failures++; $display("[TB] FAIL rr2_done got=%0h,%0h exp=1,4", q_done[0], q_done[1]); end
            checks++; if (q_addr[0] !== 8'h50 || q_addr[1] !== 8'h52) begin failures++; $display("[TB] FAIL rr2_addr got=%0h,%0h exp=50,52", q_addr[0], q_addr[1]); end
        end
        reg_map_wr_valid = 1'b0;
        cycle();
    endtask

    task automatic test_timeout();
        int n;
        int c;
        n = 0;
        reg_map_wr_valid = 1'b0;
        set_slot(3, 8'h63, 32'h33, 32'hF);
        req_cmd = 4'b1000;
        cycle();
        req_cmd = '0;
        cycle();
        checks++; if (reg_map_wr_cmd !== 1'b1 || reg_map_wr_addr !== 8'h63) begin failures++; $display("[TB] FAIL to_issue got=%0b/%0h exp=1/63", reg_map_wr_cmd, reg_map_wr_addr); end
        set_slot(1, 8'h61, 32'h11, 32'hF);
        req_cmd = 4'b0010;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            req_cmd = '0;
            if (req_done !== 4'h0) begin n = k; break; end
        end
        checks++; if (n != TO + 2) begin failures++; $display("[TB] FAIL to_latency got=%0d exp=%0d", n, TO + 2); end
        checks++; if (req_done !== 4'b1000) begin failures++; $display("[TB] FAIL to_done got=%0h exp=8", req_done); end
        checks++; if (req_err !== 2'b11) begin failures++; $display("[TB] FAIL to_err got=%0b exp=11", req_err); end
        c = 0;
        while (reg_map_wr_cmd !== 1'b1 && c < 20) begin cycle(); c++; end
        checks++; if (reg_map_wr_cmd !== 1'b1 || reg_map_wr_addr !== 8'h61) begin failures++; $display("[TB] FAIL to_next_issue got=%0b/%0h exp=1/61", reg_map_wr_cmd, reg_map_wr_addr); end
        reg_map_wr_valid = 1'b1;
        reg_map_wr_err   = 2'b01;
        c = 0;
        while (req_done === 4'h0 && c < 20) begin cycle(); c++; end
        reg_map_wr_valid = 1'b0;
        checks++; if (req_done !== 4'b0010) begin failures++; $display("[TB] FAIL errpass_done got=%0h exp=2", req_done); end
        checks++; if (req_err !== 2'b01) begin failures++; $display("[TB] FAIL errpass_err got=%0b exp=01", req_err); end
        cycle();
        cycle();
        checks++; if (req_err !== 2'b01) begin failures++; $display("[TB] FAIL errpass_hold got=%0b exp=01", req_err); end
    endtask

    task automatic test_backpressure_drop();
        logic [7:0]  q_addr[$];
        logic [31:0] q_data[$];
        int n_cmd;
        n_cmd = 0;
        reg_map_wr_ready = 1'b0;
        reg_map_wr_valid = 1'b0;
        set_slot(0, 8'h70, 32'hDEAD_0000, 32'h1);
        set_slot(2, 8'h72, 32'hBEEF_0002, 32'h2);
        req_cmd = 4'b0101;
        cycle();
        req_cmd = '0;
        checks++; if (req_ready !== 4'b1010) begin failures++; $display("[TB] FAIL bp_ready got=%0h exp=a", req_ready); end
        set_slot(0, 8'h7F, 32'hBAD0_BAD0, 32'hFFFF);
        req_cmd = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            cycle();
            req_cmd = '0;
            if (reg_map_wr_cmd === 1'b1) n_cmd++;
        end
        checks++; if (n_cmd != 0) begin failures++; $display("[TB] FAIL bp_stall got=%0d exp=0", n_cmd); end
        reg_map_wr_ready = 1'b1;
        reg_map_wr_valid = 1'b1;
        for (int c = 0; c < 25; c++) begin
            cycle();
            if (reg_map_wr_cmd === 1'b1) begin
                q_addr.push_back(reg_map_wr_addr);
                q_data.push_back(reg_map_wr_data);
            end
        end
        reg_map_wr_valid = 1'b0;
        checks++; if (q_addr.size() != 2) begin failures++; $display("[TB] FAIL bp_count got=%0d exp=2", q_addr.size()); end
        else begin
            checks++; if (q_addr[0] !== 8'h72 || q_data[0] !== 32'hBEEF_0002) begin failures++; $display("[TB] FAIL bp_first got=%0h/%0h exp=72/beef0002", q_addr[0], q_data[0]); end
            checks++; if (q_addr[1] !== 8'h70 || q_data[1] !== 32'hDEAD_0000) begin failures++; $display("[TB] FAIL bp_drop got=%0h/%0h exp=70/dead0000", q_addr[1], q_data[1]); end
        end
    endtask

    task automatic test_reset_mid_op();
        int c;
        int n_cmd;
        int n_done;
        n_cmd = 0;
        n_done = 0;
        reg_map_wr_valid = 1'b0;
        reg_map_wr_ready = 1'b1;
        for (int i = 0; i < 3; i++) set_slot(i, 8'(8'h80 + i), 32'h1234_5678, 32'hFF);
        req_cmd = 4'b0111;
        cycle();
        req_cmd = '0;
        c = 0;
        while (reg_map_wr_cmd !== 1'b1 && c < 20) begin cycle(); c++; end
        checks++; if (reg_map_wr_cmd !== 1'b1) begin failures++; $display("[TB] FAIL rst_wait_issue got=%0b exp=1", reg_map_wr_cmd); end
        cycle();
        cycle();
        aresetn = 1'b0;
        cycle();
        checks++; if (reg_map_wr_cmd !== 1'b0 || reg_map_wr_addr !== 8'h0 || reg_map_wr_data !== 32'h0 || reg_map_wr_keep !== 32'h0) begin
            failures++; $display("[TB] FAIL rst_wait_bus got=%0b/%0h/%0h/%0h exp=0/0/0/0", reg_map_wr_cmd, reg_map_wr_addr, reg_map_wr_data, reg_map_wr_keep); end
        checks++; if (req_ready !== 4'hF) begin failures++; $display("[TB] FAIL rst_wait_ready got=%0h exp=f", req_ready); end
        checks++; if (req_done !== 4'h0 || req_err !== 2'b00) begin failures++; $display("[TB] FAIL rst_wait_done_err got=%0h/%0b exp=0/00", req_done, req_err); end
        aresetn = 1'b1;
        reg_map_wr_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (reg_map_wr_cmd === 1'b1) n_cmd++;
            if (req_done !== 4'h0) n_done++;
        end
        reg_map_wr_valid = 1'b0;
        checks++; if (n_cmd != 0 || n_done != 0) begin failures++; $display("[TB] FAIL rst_after got=%0d/%0d exp=0/0", n_cmd, n_done); end
        set_slot(1, 8'h91, 32'h9, 32'h9);
        req_cmd = 4'b0010;
        cycle();
        req_cmd = '0;
        cycle();
        checks++; if (reg_map_wr_cmd !== 1'b1) begin failures++; $display("[TB] FAIL rst_issue_pre got=%0b exp=1", reg_map_wr_cmd); end
        aresetn = 1'b0;
        cycle();
        checks++; if (reg_map_wr_cmd !== 1'b0) begin failures++; $display("[TB] FAIL rst_issue_cmd got=%0b exp=0", reg_map_wr_cmd); end
        aresetn = 1'b1;
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            req_cmd          = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            req_addr         = $urandom;
            req_data         = {$urandom, $urandom, $urandom, $urandom};
            req_keep         = {$urandom, $urandom, $urandom, $urandom};
            reg_map_wr_ready = ($urandom_range(0, 3) != 0);
            reg_map_wr_valid = ($urandom_range(0, 9) < 2);
            reg_map_wr_err   = 2'($urandom_range(0, 3));
            aresetn          = ($urandom_range(0, 299) != 0);
            cycle();
            checks++; if (reg_map_wr_cmd !== m_cmd) begin failures++; $display("[TB] FAIL rnd_cmd n=%0d got=%0b exp=%0b", n, reg_map_wr_cmd, m_cmd); end
            checks++; if (reg_map_wr_addr !== m_oa) begin failures++; $display("[TB] FAIL rnd_addr n=%0d got=%0h exp=%0h", n, reg_map_wr_addr, m_oa); end
            checks++; if (reg_map_wr_data !== m_od) begin failures++; $display("[TB] FAIL rnd_data n=%0d got=%0h exp=%0h", n, reg_map_wr_data, m_od); end
            checks++; if (reg_map_wr_keep !== m_ok) begin failures++; $display("[TB] FAIL rnd_keep n=%0d got=%0h exp=%0h", n, reg_map_wr_keep, m_ok); end
            checks++; if (req_done !== m_done) begin failures++; $display("[TB] FAIL rnd_done n=%0d got=%0h exp=%0h", n, req_done, m_done); end
            checks++; if (req_err !== m_err) begin failures++; $display("[TB] FAIL rnd_err n=%0d got=%0b exp=%0b", n, req_err, m_err); end
            checks++; if (req_ready !== ~m_pend) begin failures++; $display("[TB] FAIL rnd_ready n=%0d got=%0h exp=%0h", n, req_ready, ~m_pend); end
        end
        aresetn = 1'b1;
        req_cmd = '0;
        reg_map_wr_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_timeout();
        test_backpressure_drop();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_map_wr_arbiter.md
Name: reg_map_wr_arbiter

Overview:
- Shares the single register-map write port (`reg_map_wr_*`) between NUM_REQ requesters. Requesters include the DIP-switch config controller, the Ethernet command parser and the host/debug command path.
- Each requester has a one-deep pending slot.
- A round-robin FSM issues one write at a time, waits for completion or timeout, then returns a done pulse and error status to the granted requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 16'd1023, cycles waited in WAIT for `reg_map_wr_valid` before a write is declared timed out.

Ports:
- aclk  input  1  clock.
- aresetn  input  1  reset.
- req_cmd  input  NUM_REQ  per-requester write strobe, single cycle.
- req_addr  input  8*NUM_REQ  register address; requester i uses bits [8i+7:8i].
- req_data  input  32*NUM_REQ  write data; requester i uses bits [32i+31:32i].
- req_keep  input  32*NUM_REQ  per-bit write enable; requester i uses bits [32i+31:32i].
- req_ready  output  NUM_REQ  requester slot is free.
- req_done  output  NUM_REQ  one-cycle completion pulse.
- req_err  output  2  error status of the most recent completion.
- reg_map_wr_cmd  output  1  write strobe to the register map.
- reg_map_wr_addr  output  8  address to the register map.
- reg_map_wr_data  output  32  data to the register map.
- reg_map_wr_keep  output  32  bit mask to the register map.
- reg_map_wr_valid  input  1  register map write-complete indication.
- reg_map_wr_ready  input  1  register map can accept a command.
- reg_map_wr_err  input  2  register map error code, qualified by `reg_map_wr_valid`.

Behaviour:
- Clock and reset: clock aclk; reset aresetn, synchronous, active-low.
- All registers clear on reset: pending[], captured addr/data/keep, state = IDLE, timeout counter, grant index, `req_err`.
- Round-robin last-grant pointer resets to NUM_REQ-1, so requester 0 has first priority.
- Output reset values:
  - `reg_map_wr_cmd` = 0; `reg_map_wr_addr`, `reg_map_wr_data`, `reg_map_wr_keep` = 0.
  - `req_done` = 0; `req_err` = 2'b00.
  - `req_ready` = all ones, because it is the combinational inverse of pending[].
- Slot capture:
  - If `req_cmd[i]` and `req_ready[i]` at edge T, requester i's addr/data/keep are latched into slot i and pending[i] = 1 from T+1.
  - `req_cmd[i]` while `req_ready[i]` = 0 is ignored and dropped. Requesters must wait for `req_ready`.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any pending bit is set and `reg_map_wr_ready` = 1, select the first pending index searching from (last+1) mod NUM_REQ upward with wrap. Register it as the grant and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - `reg_map_wr_cmd` = 1, with `reg_map_wr_addr`, `reg_map_wr_data`, `reg_map_wr_keep` driven from the granted slot. All are registered outputs.
  - Clear the timeout counter and go to WAIT.
  - addr/data/keep hold their value after ISSUE until the next ISSUE.
- WAIT:
  - If `reg_map_wr_valid` = 1, capture `reg_map_wr_err` and go to DONE.
  - Else if the counter equals TIMEOUT, set captured err = 2'b11 and go to DONE.
  - Else increment the counter.
  - `reg_map_wr_valid` is sampled only in WAIT; it is ignored in every other state.
  - If valid and timeout coincide in the same cycle, valid wins.
- DONE (1 cycle):
  - `req_done[grant]` = 1 and `req_err` = captured err. `req_err` holds until the next DONE.
  - Clear pending[grant], set last = grant, go to IDLE.
- Latency (single request, idle arbiter, `reg_map_wr_ready` = 1):
  - `req_cmd` at T → `reg_map_wr_cmd` high at T+2.
  - Valid first seen in WAIT at cycle V → `req_done` at V+1 → `req_ready[i]` high at V+2.
  - Minimum request-to-done is 4 cycles.
- Simultaneous events:
  - A new `req_cmd[j]` at the DONE cycle for j ≠ grant is captured normally.
  - Requester grant's slot reopens only after DONE.
- `reg_map_wr_ready` is evaluated only in IDLE. A drop of `reg_map_wr_ready` in ISSUE/WAIT does not abort the transaction.
- Reset mid-operation returns all state to the reset values.
  - All pending requests are discarded.
  - No `req_done` is issued for them.
  - If reset occurs in ISSUE, `reg_map_wr_cmd` goes to 0 on the next edge.
- Never more than one outstanding register-map write. `req_done` is one-hot or zero.

Test Plan:
- Single write: `req_cmd[1]` at T, addr 8'h23, data 32'h2, keep 32'h3, valid with err 2'b00 two cycles after cmd → `reg_map_wr_cmd` pulse at T+2 carrying 8'h23/32'h2/32'h3; `req_done` = 4'b0010 one cycle after valid; `req_err` = 0; `req_ready[1]` high again 2 cycles after valid.
- Round robin: all four requesters pulse `req_cmd` in the same cycle after reset, each write completed in 1 cycle → grant order 0,1,2,3. Then requesters 0 and 2 request again while last = 3 → order 0, then 2.
- Timeout: `reg_map_wr_valid` never asserted, TIMEOUT = 16 → `req_done` exactly 17 cycles after entering WAIT, with `req_err` = 2'b11; next pending request is then served.
- Back-pressure and drop: `reg_map_wr_ready` = 0 with 2 pending → no `reg_map_wr_cmd` until ready rises. A second `req_cmd[0]` while `req_ready[0]` = 0 does not alter slot 0 data or add a write.
- Error pass-through and reset mid-WAIT: valid with err 2'b01 → `req_err` = 2'b01. Assert aresetn = 0 while in WAIT with 3 pending → all outputs at reset values, `req_ready` = 4'hF, no `req_done` after release.
